// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight E/M/W register writes and derives the ID
// stall plus per-operand forward-source selects from {addr, Tnew} records.
module hazard_scoreboard #(
    parameter int TNEW_W  = 3,
    parameter int TNEW_WB = 7,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pipe_adv,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_wr_addr,
    input  logic [TNEW_W-1:0] id_tnew,
    input  logic [4:0]        id_rs_addr,
    input  logic [4:0]        id_rt_addr,
    input  logic [1:0]        id_rs_tuse,
    input  logic [1:0]        id_rt_tuse,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [TNEW_W-1:0] WB = TNEW_W'(TNEW_WB);

    typedef struct packed {
        logic       hazard;
        logic [1:0] sel;
    } match_t;

    logic              e_valid, m_valid, w_valid;
    logic [4:0]        e_addr, m_addr, w_addr;
    logic [TNEW_W-1:0] e_tnew, m_tnew, w_tnew;

    match_t rs_match, rt_match;

    // Moving one stage brings the result one step closer; WB results only
    // become available in W, so their code is left untouched.
    function automatic logic [TNEW_W-1:0] age(input logic [TNEW_W-1:0] t);
        return (t == WB || t == '0) ? t : t - TNEW_W'(1);
    endfunction

    // Youngest matching entry wins (E > M > W); sel reports its stage even
    // when the operand is not ready yet.
    function automatic match_t source_match(input logic [4:0] r,
                                            input logic [1:0] tuse);
        match_t            m;
        logic [TNEW_W-1:0] t;
        logic              in_w;
        m    = '0;
        t    = '0;
        in_w = 1'b0;
        if (r != 5'd0) begin
            if (e_valid && e_addr == r) begin
                m.sel = 2'd1;
                t     = e_tnew;
            end else if (m_valid && m_addr == r) begin
                m.sel = 2'd2;
                t     = m_tnew;
            end else if (w_valid && w_addr == r) begin
                m.sel = 2'd3;
                t     = w_tnew;
                in_w  = 1'b1;
            end
            if (m.sel != 2'd0) begin
                if (t == WB) m.hazard = ~in_w;
                else         m.hazard = (t > TNEW_W'(tuse));
            end
        end
        return m;
    endfunction

    always_comb begin
        rs_match = source_match(id_rs_addr, id_rs_tuse);
        rt_match = source_match(id_rt_addr, id_rt_tuse);
    end

    assign stall      = id_valid & (rs_match.hazard | rt_match.hazard);
    assign fwd_rs_sel = rs_match.sel;
    assign fwd_rt_sel = rt_match.sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_valid   <= 1'b0;
            m_valid   <= 1'b0;
            w_valid   <= 1'b0;
            e_addr    <= '0;
            m_addr    <= '0;
            w_addr    <= '0;
            e_tnew    <= '0;
            m_tnew    <= '0;
            w_tnew    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
            if (pipe_adv) begin
                // Flush kills both the entries moving forward and the new insertion.
                w_valid <= m_valid & ~flush;
                w_addr  <= m_addr;
                w_tnew  <= age(m_tnew);
                m_valid <= e_valid & ~flush;
                m_addr  <= e_addr;
                m_tnew  <= age(e_tnew);
                e_valid <= id_valid & ~stall & (id_wr_addr != 5'd0) & ~flush;
                e_addr  <= id_wr_addr;
                e_tnew  <= id_tnew;
            end else if (flush) begin
                e_valid <= 1'b0;
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset corner case and
// randomized traffic against a queue-based pipeline model.
module tb_hazard_scoreboard;

    localparam int TNEW_W  = 3;
    localparam int TNEW_WB = 7;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              pipe_adv = 1'b0;
    logic              flush = 1'b0;
    logic              id_valid = 1'b0;
    logic [4:0]        id_wr_addr = '0;
    logic [TNEW_W-1:0] id_tnew = '0;
    logic [4:0]        id_rs_addr = '0;
    logic [4:0]        id_rt_addr = '0;
    logic [1:0]        id_rs_tuse = '0;
    logic [1:0]        id_rt_tuse = '0;
    logic              stall;
    logic [1:0]        fwd_rs_sel;
    logic [1:0]        fwd_rt_sel;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.TNEW_W(TNEW_W), .TNEW_WB(TNEW_WB), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pipe_adv   (pipe_adv),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_wr_addr (id_wr_addr),
        .id_tnew    (id_tnew),
        .id_rs_addr (id_rs_addr),
        .id_rt_addr (id_rt_addr),
        .id_rs_tuse (id_rs_tuse),
        .id_rt_tuse (id_rt_tuse),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stall_cnt  (stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic adv, input logic fl, input logic v,
                         input logic [4:0] wr, input logic [2:0] tn,
                         input logic [4:0] rs, input logic [1:0] rsu,
                         input logic [4:0] rt, input logic [1:0] rtu);
        pipe_adv   = adv;
        flush      = fl;
        id_valid   = v;
        id_wr_addr = wr;
        id_tnew    = tn;
        id_rs_addr = rs;
        id_rs_tuse = rsu;
        id_rt_addr = rt;
        id_rt_tuse = rtu;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       adv, fl, v;
        logic [4:0] wr;
        logic [2:0] tn;
        logic [4:0] rs;
        logic [1:0] rsu;
        logic [4:0] rt;
        logic [1:0] rtu;
        logic       e_stall;
        logic [1:0] e_rs, e_rt;
        int         e_cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic adv, input logic fl, input logic v,
                                input int wr, input int tn, input int rs, input int rsu,
                                input int rt, input int rtu,
                                input logic st, input int srs, input int srt, input int cnt);
        vec_t x;
        x.adv = adv; x.fl = fl; x.v = v;
        x.wr = 5'(wr); x.tn = 3'(tn);
        x.rs = 5'(rs); x.rsu = 2'(rsu); x.rt = 5'(rt); x.rtu = 2'(rtu);
        x.e_stall = st; x.e_rs = 2'(srs); x.e_rt = 2'(srt); x.e_cnt = cnt;
        return x;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic       v;
        logic [4:0] a;
        int         t;
    } ent_t;

    ent_t pq[$];          // index 0 = E, 1 = M, 2 = W
    logic [31:0] exp_cnt;

    function automatic void ref_match(input logic [4:0] r, input int tuse,
                                      output logic hz, output logic [1:0] sel);
        hz  = 1'b0;
        sel = 2'd0;
        if (r == 5'd0) return;
        foreach (pq[i]) begin
            if (pq[i].v && pq[i].a == r) begin
                sel = 2'(i + 1);
                if (pq[i].t == TNEW_WB) hz = (i != 2);
                else                    hz = (pq[i].t > tuse);
                return;
            end
        end
    endfunction

    task automatic model_reset();
        ent_t z;
        z.v = 1'b0; z.a = '0; z.t = 0;
        pq.delete();
        for (int i = 0; i < 3; i++) pq.push_back(z);
        exp_cnt = '0;
    endtask

    task automatic model_step(input logic st);
        ent_t n;
        if (st) exp_cnt = exp_cnt + 32'd1;
        if (pipe_adv) begin
            n.v = id_valid && !st && (id_wr_addr != 5'd0);
            n.a = id_wr_addr;
            n.t = int'(id_tnew);
            void'(pq.pop_back());
            pq.push_front(n);
            for (int i = 1; i < 3; i++) begin
                ent_t e;
                e = pq[i];
                if (e.t != TNEW_WB && e.t > 0) e.t = e.t - 1;
                pq[i] = e;
            end
        end
        if (flush) begin
            for (int i = 0; i < 3; i++) begin
                ent_t e;
                e = pq[i];
                if (i < 2 || pipe_adv) e.v = 1'b0;
                pq[i] = e;
            end
        end
    endtask

    initial begin
        logic       hz_rs, hz_rt, e_st;
        logic [1:0] s_rs, s_rt;

        // Test plan 1..5 as one continuous directed sequence.
        tbl[0]  = mk(1,0,1, 1,0, 0,0, 0,0,  0,0,0,0);
        tbl[1]  = mk(1,0,1, 2,0, 1,1, 0,0,  0,1,0,0);
        tbl[2]  = mk(1,0,1, 0,0, 1,1, 2,1,  0,2,1,0);
        tbl[3]  = mk(1,0,1, 0,0, 1,0, 2,0,  0,3,2,0);
        tbl[4]  = mk(1,0,1, 3,1, 0,0, 0,0,  0,0,0,0);
        tbl[5]  = mk(1,0,1, 0,0, 3,0, 0,0,  1,1,0,0);
        tbl[6]  = mk(1,0,1, 0,0, 3,0, 0,0,  0,2,0,1);
        tbl[7]  = mk(1,0,1, 4,7, 0,0, 0,0,  0,0,0,1);
        tbl[8]  = mk(1,0,1, 0,0, 4,1, 0,0,  1,1,0,1);
        tbl[9]  = mk(1,0,1, 0,0, 4,1, 0,0,  1,2,0,2);
        tbl[10] = mk(1,0,1, 0,0, 4,1, 0,0,  0,3,0,3);
        tbl[11] = mk(1,0,1, 5,0, 0,0, 0,0,  0,0,0,3);
        tbl[12] = mk(1,0,0, 0,0, 0,0, 0,0,  0,0,0,3);
        tbl[13] = mk(1,0,1, 5,1, 0,0, 0,0,  0,0,0,3);
        tbl[14] = mk(0,0,1, 0,0, 5,0, 0,0,  1,1,0,3);
        tbl[15] = mk(0,0,1, 0,0, 5,0, 0,0,  1,1,0,4);
        tbl[16] = mk(0,0,1, 0,0, 5,0, 0,0,  1,1,0,5);
        tbl[17] = mk(1,1,1, 0,0, 5,0, 0,0,  1,1,0,6);
        tbl[18] = mk(0,0,1, 0,0, 5,0, 0,0,  0,0,0,7);

        // Reset state, with ID presenting a would-be hazard source.
        drive(0,0,1, 0,0, 5'd3,0, 5'd4,0);
        #12;
        check("reset_stall", 32'(stall), 0);
        check("reset_rs_sel", 32'(fwd_rs_sel), 0);
        check("reset_rt_sel", 32'(fwd_rt_sel), 0);
        check("reset_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].adv, tbl[i].fl, tbl[i].v, tbl[i].wr, tbl[i].tn,
                  tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu);
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d_rs_sel", i), 32'(fwd_rs_sel), 32'(tbl[i].e_rs));
            check($sformatf("vec%0d_rt_sel", i), 32'(fwd_rt_sel), 32'(tbl[i].e_rt));
            check($sformatf("vec%0d_cnt", i), stall_cnt, 32'(tbl[i].e_cnt));
            @(posedge clk); #1;
        end

        // Asynchronous reset while stalled.
        drive(1,0,1, 5'd6,3'd2, 0,0, 0,0);
        @(posedge clk); #1;
        drive(0,0,1, 0,0, 5'd6,0, 0,0);
        @(negedge clk);
        check("pre_reset_stall", 32'(stall), 1);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_stall", 32'(stall), 0);
        check("async_reset_cnt", stall_cnt, 0);
        check("async_reset_rs_sel", 32'(fwd_rs_sel), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        drive(1,0,1, 5'd7,0, 5'd6,0, 5'd6,1);
        @(negedge clk);
        check("post_reset_rs_sel", 32'(fwd_rs_sel), 0);
        check("post_reset_rt_sel", 32'(fwd_rt_sel), 0);
        check("post_reset_stall", 32'(stall), 0);
        @(posedge clk); #1;

        // Randomized traffic against the model.
        resetn = 1'b0;
        model_reset();
        drive(0,0,0, 0,0, 0,0, 0,0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            int k;
            pipe_adv   = ($urandom_range(0, 9) < 8);
            flush      = ($urandom_range(0, 24) == 0);
            id_valid   = ($urandom_range(0, 9) < 8);
            id_wr_addr = 5'($urandom_range(0, 6));
            k          = $urandom_range(0, 4);
            id_tnew    = (k == 4) ? 3'(TNEW_WB) : 3'(k);
            id_rs_addr = 5'($urandom_range(0, 6));
            id_rt_addr = 5'($urandom_range(0, 6));
            id_rs_tuse = 2'($urandom_range(0, 3));
            id_rt_tuse = 2'($urandom_range(0, 3));
            @(negedge clk);
            ref_match(id_rs_addr, int'(id_rs_tuse), hz_rs, s_rs);
            ref_match(id_rt_addr, int'(id_rt_tuse), hz_rt, s_rt);
            e_st = id_valid & (hz_rs | hz_rt);
            check("rand_stall", 32'(stall), 32'(e_st));
            check("rand_rs_sel", 32'(fwd_rs_sel), 32'(s_rs));
            check("rand_rt_sel", 32'(fwd_rt_sel), 32'(s_rt));
            check("rand_cnt", stall_cnt, exp_cnt);
            model_step(e_st);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
